seq_multiplier_param: RTL



---
 rtl/seq_multiplier_param.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seq_multiplier_param.sv
// Purpose  : shift-and-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH, runtime signed/unsigned.
// Latency  : start accepted at edge t0 -> done pulse after edge t0+WIDTH+1 (early-exit build: fewer).
// Backpres.: none; start is only sampled in IDLE, requests while busy are dropped.
//
// Optional feature macro: SEQ_MULT_EARLY_EXIT_EN
//   defined   -> CALC leaves as soon as the remaining multiplier bits are all zero
//   undefined -> always WIDTH iterations
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; aborts any operation in flight
//   start        operation request, sampled only in IDLE
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b         multiplicand / multiplier (sampled with start)
//   busy         high while an operation is in progress
//   done         one-cycle pulse, product valid
//   product      2*WIDTH-bit result, held until the next done
module seq_multiplier_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [WIDTH-1:0]  mcand_q;
   logic [WIDTH-1:0]  mplr_q;
   logic [PW-1:0]     acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              neg_q;
   logic [PW-1:0]     product_q;
   logic              done_q;

   logic [WIDTH-1:0]  a_mag;
   logic [WIDTH-1:0]  b_mag;
   logic [WIDTH-1:0]  mplr_shift;
   logic [PW-1:0]     addend;
   logic [PW-1:0]     acc_next;
   logic              last_iter;

   // Magnitudes are taken only for negative signed operands. The most negative
   // value maps onto 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
   assign a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

   // Partial product for the current multiplier bit; the sum stays within
   // 2*WIDTH bits because both magnitudes are at most 2^(WIDTH-1)..2^WIDTH-1.
   assign addend     = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
   assign acc_next   = mplr_q[0] ? (acc_q + addend) : acc_q;
   assign mplr_shift = mplr_q >> 1;

`ifdef SEQ_MULT_EARLY_EXIT_EN
   // Remaining multiplier bits all zero: further iterations add nothing.
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (mplr_shift == '0);
`else
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and status outputs
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (last_iter) begin
               state_d = FIN;
            end
         end
         FIN: begin
            busy    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= (state_q == FIN);
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q <= a_mag;
                  mplr_q  <= b_mag;
                  neg_q   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            CALC: begin
               acc_q  <= acc_next;
               mplr_q <= mplr_shift;
               cnt_q  <= cnt_q + CNT_W'(1);
            end
            FIN: begin
               // negating zero yields zero, so a zero operand needs no special case
               product_q <= neg_q ? (~acc_q + PW'(1)) : acc_q;
            end
            default: begin
            end
         endcase
      end
   end

   assign done    = done_q;
   assign product = product_q;

endmodule
